unsigned_sqrt_iter: RTL and testbench
=====================================

UNSIGNED_SQRT_ITER -- requirements
Module: unsigned_sqrt_iter

Interface
REQ-001 The block SHALL have no parameters; input width is fixed at 16 bits, root at 8 bits, remainder at 9 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 data_i  input  16  unsigned radicand X; sampled only on the accept edge.
REQ-005 valid_i  input  1  upstream asserts when data_i is valid.
REQ-006 ready_o  output  1  block can accept a new radicand.
REQ-007 root_o  output  8  floor(sqrt(X)).
REQ-008 rem_o  output  9  X - root_o^2.
REQ-009 valid_o  output  1  root_o and rem_o are valid.
REQ-010 ready_i  input  1  downstream accepts the result.

Function
REQ-011 The block SHALL be an iterative restoring square-root unit that inverts the team's 8x8 unsigned squarer: for any X, root_o^2 + rem_o = X and rem_o <= 2*root_o.
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 ready_o SHALL equal 1 only in IDLE.
REQ-014 Accept SHALL occur on an edge with valid_i=1 in IDLE; the block SHALL latch data_i, clear the partial root and remainder, load iteration counter 0, and enter CALC.
REQ-015 In IDLE with valid_i=0, the block SHALL hold its state.
REQ-016 Each CALC cycle SHALL run one iteration, consuming the radicand from its 2 MSBs down to its 2 LSBs.
REQ-017 The iteration step SHALL be: r = (r<<2) | next two bits; t = (q<<2) | 1; if r >= t then r = r - t and q = (q<<1) | 1, else q = q<<1.
REQ-018 The internal remainder SHALL be at least 10 bits wide so that the shift cannot overflow.
REQ-019 After the 8th iteration (counter = 7), the FSM SHALL move to DONE.
REQ-020 valid_o SHALL first be high in the cycle following the 8th edge after the accept edge, so the latency is 8 cycles.
REQ-021 valid_o SHALL be 1 only in DONE.
REQ-022 In DONE, root_o and rem_o SHALL hold stable while ready_i=0, regardless of valid_i or data_i.
REQ-023 On an edge with valid_o=1 and ready_i=1, the FSM SHALL return to IDLE; the next accept can occur no earlier than the following edge.
REQ-024 Peak throughput SHALL be one result per 10 cycles.
REQ-025 root_o and rem_o SHALL retain the last result in IDLE and CALC until a new result is written on entry to DONE.
REQ-026 Inputs SHALL be ignored in CALC and DONE.
REQ-027 ready_i SHALL be ignored outside DONE.
REQ-028 The counter SHALL be 3 bits and SHALL NOT wrap into a 9th iteration.

Reset
REQ-029 When rst=1 on a clock edge, the block SHALL enter IDLE and clear root_o, rem_o, internal root, remainder and counter to 0; after that edge ready_o=1 and valid_o=0.
REQ-030 Reset SHALL take priority over every other event, including an accept or a DONE handshake on the same edge.
REQ-031 Reset asserted mid-CALC or in DONE SHALL abandon the operation without producing valid_o.
REQ-032 valid_i=1 during rst=1 SHALL NOT be accepted.

Verification
REQ-033 The bench SHALL drive X=0, 2, 15 and 255 with ready_i=1 and check root/rem = 0/0, 1/1, 3/6 and 15/30, with valid_o 8 cycles after accept.
REQ-034 The bench SHALL cover boundaries: X=65025 -> 255/0 and X=65535 -> 255/510, the maximum remainder, with no overflow.
REQ-035 The bench SHALL hold ready_i=0 for 5 cycles in DONE, confirm valid_o, root_o and rem_o are stable and ready_o=0, then confirm return to IDLE one edge after ready_i=1.
REQ-036 The bench SHALL change data_i and pulse valid_i during CALC, confirm the result matches the originally accepted X, and confirm no second accept occurs.
REQ-037 The bench SHALL assert rst at iteration 4 and confirm valid_o never rises and all outputs are 0 with ready_o=1 the cycle after; a following X=100 SHALL give 10/0.
REQ-038 The bench SHALL run back-to-back random X with random ready_i, check root^2 + rem = X and rem <= 2*root for every result, and check the result count equals the accept count.

Source files
------------

// File: rtl/unsigned_sqrt_iter.sv
// Iterative restoring square root: 16-bit radicand -> 8-bit root and 9-bit remainder.
// One radicand bit-pair is consumed per CALC cycle, MSB pair first, so a result takes 8 cycles.
module unsigned_sqrt_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [7:0]  root_o,
    output logic [8:0]  rem_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [1:0]  dbg_state_o
);
    // Handshake: a radicand is taken on an edge where valid_i && ready_o, and a
    // result is released on an edge where valid_o && ready_i; no other edge moves data.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_x;
    logic [7:0]  r_q;
    logic [9:0]  r_rem;
    logic [2:0]  r_cnt;
    logic [7:0]  r_root_o;
    logic [8:0]  r_rem_o;

    logic [9:0]  w_r;
    logic [9:0]  w_t;
    logic        w_ge;
    logic [7:0]  w_q_next;
    logic [9:0]  w_rem_next;

    // r_x is shifted left each iteration, so its top pair is always the next pair to consume.
    always_comb begin
        w_r        = {r_rem[7:0], r_x[15:14]};
        w_t        = {r_q, 2'b01};
        w_ge       = (w_r >= w_t);
        w_q_next   = {r_q[6:0], w_ge};
        w_rem_next = w_ge ? (w_r - w_t) : w_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (valid_i) w_next_state = S_CALC;
            S_CALC: if (r_cnt == 3'd7) w_next_state = S_DONE;
            S_DONE: if (ready_i) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o     = (r_state == S_IDLE);
        valid_o     = (r_state == S_DONE);
        dbg_state_o = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_root_o <= '0;
            r_rem_o  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_x   <= data_i;
                        r_q   <= '0;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_x   <= {r_x[13:0], 2'b00};
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    // Last iteration publishes the result; counter stays at 7 rather than wrapping.
                    if (r_cnt == 3'd7) begin
                        r_root_o <= w_q_next;
                        r_rem_o  <= w_rem_next[8:0];
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign root_o = r_root_o;
    assign rem_o  = r_rem_o;

endmodule

// File: tb/tb_unsigned_sqrt_iter.sv
// Scoreboard bench for unsigned_sqrt_iter: driver pushes expected root/rem, a
// negedge monitor pops and compares on every output handshake.
module tb_unsigned_sqrt_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  root_o;
    logic [8:0]  rem_o;
    logic        valid_o;
    logic        ready_i;
    logic [1:0]  dbg_state_o;

    unsigned_sqrt_iter dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .root_o      (root_o),
        .rem_o       (rem_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [16:0] exp_q[$];
    int          x_q[$];
    int          acc_q[$];
    int          total = 0;
    int          bad   = 0;
    int          n_acc = 0;
    int          n_res = 0;
    bit          prev_v = 1'b0;
    bit          rand_done;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: smallest-integer search for floor(sqrt(x)), remainder by subtraction.
    function automatic logic [16:0] model(input int x);
        int r;
        logic [7:0] rv;
        logic [8:0] mv;
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        rv = 8'(r);
        mv = 9'(x - r * r);
        return {rv, mv};
    endfunction

    always @(negedge clk) begin
        if (!rst && valid_o && !prev_v) begin
            if (acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), 8);
            else chk("latency_no_accept", 1, 0);
        end
        if (!rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", int'(root_o), -1);
            end else begin
                logic [16:0] e;
                int          x;
                e = exp_q.pop_front();
                x = x_q.pop_front();
                chk("root", int'(root_o), int'(e[16:9]));
                chk("rem", int'(rem_o), int'(e[8:0]));
                chk("root2_plus_rem", int'(root_o) * int'(root_o) + int'(rem_o), x);
                chk("rem_le_2root", int'(int'(rem_o) <= 2 * int'(root_o)), 1);
                n_res++;
            end
        end
        prev_v = valid_o && !rst;
    end

    // Leaves with valid_i low, #1 after the accept edge.
    task automatic send(input int x, input bit push, input logic [16:0] e);
        int k;
        @(negedge clk);
        data_i  = 16'(x);
        valid_i = 1'b1;
        k = 0;
        while (!ready_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ready_o) begin
            chk("accept_timeout", 0, 1);
            valid_i = 1'b0;
            return;
        end
        if (push) begin
            exp_q.push_back(e);
            x_q.push_back(x);
            acc_q.push_back(cyc + 1);
            n_acc++;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data_i  = 16'($urandom);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!valid_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!valid_o) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int directed_x[6];
        logic [16:0] directed_e[6];
        logic [16:0] e;
        directed_x = '{0, 2, 15, 255, 65025, 65535};
        directed_e = '{{8'd0, 9'd0}, {8'd1, 9'd1}, {8'd3, 9'd6},
                       {8'd15, 9'd30}, {8'd255, 9'd0}, {8'd255, 9'd510}};

        // Reset with valid_i high: must not be taken.
        rst     = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'd1234;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("reset_ready", int'(ready_o), 1);
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_root", int'(root_o), 0);
        chk("reset_rem", int'(rem_o), 0);

        foreach (directed_x[i]) begin
            send(directed_x[i], 1'b1, directed_e[i]);
            wait_drain(50);
        end

        // Back-pressure hold in DONE while inputs wiggle.
        ready_i = 1'b0;
        e = model(60000);
        send(60000, 1'b1, e);
        wait_valid(50);
        for (int i = 0; i < 5; i++) begin
            data_i  = 16'($urandom);
            valid_i = 1'(i % 2);
            chk("hold_valid", int'(valid_o), 1);
            chk("hold_ready", int'(ready_o), 0);
            chk("hold_root", int'(root_o), int'(e[16:9]));
            chk("hold_rem", int'(rem_o), int'(e[8:0]));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("return_idle_ready", int'(ready_o), 1);
        chk("return_idle_valid", int'(valid_o), 0);
        wait_drain(20);

        // Input changes during CALC are ignored.
        send(12345, 1'b1, model(12345));
        for (int i = 0; i < 4; i++) begin
            data_i  = 16'($urandom);
            valid_i = 1'b1;
            @(negedge clk);
            chk("calc_ready_low", int'(ready_o), 0);
            @(posedge clk);
            #1;
            valid_i = 1'b0;
        end
        wait_drain(50);
        repeat (12) begin
            @(negedge clk);
            chk("no_second_accept", int'(valid_o), 0);
        end

        // Abort with reset mid-computation, valid_i held high during it.
        send(777, 1'b0, '0);
        repeat (4) @(posedge clk);
        #1;
        rst     = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'd5;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("abort_ready", int'(ready_o), 1);
        chk("abort_valid", int'(valid_o), 0);
        chk("abort_root", int'(root_o), 0);
        chk("abort_rem", int'(rem_o), 0);
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_valid", int'(valid_o), 0);
        end
        send(100, 1'b1, {8'd10, 9'd0});
        wait_drain(50);

        // Random back-to-back traffic with random downstream stalls.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int x;
                    if ($urandom_range(0, 3) == 0) begin
                        x = $urandom_range(0, 255);
                        x = x * x;
                    end else begin
                        x = $urandom_range(0, 65535);
                    end
                    send(x, 1'b1, model(x));
                    if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        ready_i = 1'b1;
        wait_drain(100);
        chk("result_count", n_res, n_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
